// File: rtl/ps2_scan_decoder_if.sv
// PS/2 scan decoder bus: receiver-side byte input plus event FIFO output.
// slave = decoder side, master = consumer/driver side.
interface ps2_scan_decoder_if #(
    parameter int DEPTH = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              scan_valid;
    logic [7:0]        scan_code;
    logic              rx_en;
    logic              evt_valid;
    logic [7:0]        evt_code;
    logic              evt_ext;
    logic              evt_brk;
    logic              evt_rd;
    logic [ADDR_W:0]   evt_count;
    logic              shift_held;
    logic              overflow;
    logic              proto_err;
    logic              clr_flags;

    modport slave (
        input  scan_valid, scan_code, evt_rd, clr_flags,
        output rx_en, evt_valid, evt_code, evt_ext, evt_brk,
               evt_count, shift_held, overflow, proto_err
    );

    modport master (
        output scan_valid, scan_code, evt_rd, clr_flags,
        input  rx_en, evt_valid, evt_code, evt_ext, evt_brk,
               evt_count, shift_held, overflow, proto_err
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Folds PS/2 E0/F0/E1 prefix sequences into key events queued in a
// first-word-fall-through FIFO; tracks shift state and receiver flow control.
module ps2_scan_decoder #(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    ps2_scan_decoder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t            state;
    logic [2:0]        skip_cnt;
    logic [9:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              lshift;
    logic              rshift;
    logic              overflow_q;
    logic              proto_q;

    logic [7:0]        code;
    logic              bad;
    logic              err;
    logic              push;
    logic [9:0]        push_data;
    logic              full;
    logic              empty;
    logic              pop;
    logic              wr;
    logic              drop;
    logic [9:0]        head;

    assign code  = bus.scan_code;
    assign bad   = (code == 8'h00) || (code == 8'hFF);
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = bus.evt_rd & ~empty;
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // push_data = {ext, brk, code}
    always_comb begin
        err       = 1'b0;
        push      = 1'b0;
        push_data = {2'b00, code};
        if (bus.scan_valid) begin
            case (state)
                IDLE: begin
                    unique case (1'b1)
                        bad: err = 1'b0 | 1'b1;
                        (code == 8'hE0), (code == 8'hF0),
                        (code == 8'hE1), (code == 8'hAA),
                        (code == 8'hFA), (code == 8'hEE),
                        (code == 8'hFE): push = 1'b0;
                        default: push = 1'b1;
                    endcase
                end
                EXT: begin
                    if (bad) err = 1'b1;
                    else if (code != 8'hF0 && code != 8'hE0) begin
                        push      = 1'b1;
                        push_data = {2'b10, code};
                    end
                end
                BRK: begin
                    if (bad) err = 1'b1;
                    else begin
                        push      = 1'b1;
                        push_data = {2'b01, code};
                    end
                end
                EXT_BRK: begin
                    if (bad) err = 1'b1;
                    else begin
                        push      = 1'b1;
                        push_data = {2'b11, code};
                    end
                end
                PAUSE: begin
                    if (skip_cnt == 3'd1) begin
                        push      = 1'b1;
                        push_data = {2'b00, 8'hE1};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else if (bus.scan_valid) begin
            case (state)
                IDLE: begin
                    if (code == 8'hE0) state <= EXT;
                    else if (code == 8'hF0) state <= BRK;
                    else if (code == 8'hE1) begin
                        state    <= PAUSE;
                        skip_cnt <= 3'd7;
                    end
                end
                EXT: begin
                    if (bad) state <= IDLE;
                    else if (code == 8'hF0) state <= EXT_BRK;
                    else if (code != 8'hE0) state <= IDLE;
                end
                BRK, EXT_BRK: state <= IDLE;
                PAUSE: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop) count <= count + 1'b1;
            else if (pop && !wr) count <= count - 1'b1;
        end
    end

    // Shift tracking follows the decoded stream even when the FIFO drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (push && !push_data[9]) begin
            if (push_data[7:0] == 8'h12) lshift <= ~push_data[8];
            if (push_data[7:0] == 8'h59) rshift <= ~push_data[8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            else if (bus.clr_flags) overflow_q <= 1'b0;
            if (err) proto_q <= 1'b1;
            else if (bus.clr_flags) proto_q <= 1'b0;
        end
    end

    assign head           = empty ? 10'd0 : mem[rd_ptr];
    assign bus.evt_valid  = ~empty;
    assign bus.evt_code   = head[7:0];
    assign bus.evt_brk    = head[8];
    assign bus.evt_ext    = head[9];
    assign bus.evt_count  = count;
    assign bus.rx_en      = ~full;
    assign bus.shift_held = lshift | rshift;
    assign bus.overflow   = overflow_q;
    assign bus.proto_err  = proto_q;
endmodule
